// File: rtl/mips_bootmem_if.sv
// Loader handshake and core memory bus for mips_bootmem.
// master drives loader/core requests; slave is the memory.
interface mips_bootmem_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;

  modport master (
    output load_valid,
    output load_data,
    output memread,
    output memwrite,
    output adr,
    output writedata,
    input  load_ready,
    input  memdata
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  memread,
    input  memwrite,
    input  adr,
    input  writedata,
    output load_ready,
    output memdata
  );
endinterface

// File: rtl/mips_bootmem.sv
// Boot memory for the multicycle mips core: streaming loader, then RAM.
// Optional trailing checksum byte enabled by BOOTMEM_CHECKSUM_EN.
module mips_bootmem #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           reload,
  mips_bootmem_if.slave  bus,
  output logic           cpu_reset,
  output logic           boot_done,
  output logic           boot_err
);

  localparam int DEPTH = 1 << WIDTH;

`ifdef BOOTMEM_CHECKSUM_EN
  typedef enum logic [2:0] {
    LEN, DATA, CHK, RUN, ERR
  } state_t;
`else
  typedef enum logic [1:0] {
    LEN, DATA, RUN
  } state_t;
`endif

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] ptr;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             xfer;
  logic             last;
  logic             run;

  assign xfer = bus.load_valid & bus.load_ready;
  assign last = (rem == (WIDTH+1)'(1));
  assign run  = (state == RUN);

`ifdef BOOTMEM_CHECKSUM_EN
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] sum_nx;

  assign sum_nx = sum + bus.load_data;

  assign bus.load_ready = (state == LEN)
                        | (state == DATA)
                        | (state == CHK);
  assign boot_err = (state == ERR);
`else
  assign bus.load_ready = (state == LEN)
                        | (state == DATA);
  assign boot_err = 1'b0;
`endif

  assign cpu_reset = !run;
  assign boot_done = run;
  assign bus.memdata = (run & bus.memread)
                     ? mem[bus.adr] : '0;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LEN;
    else        state <= state_nx;
  end

  // Next-state: load sequence, run, reload
  always_comb begin
    state_nx = state;
    case (state)
      LEN: begin
        if (xfer) state_nx = DATA;
      end
      DATA: begin
`ifdef BOOTMEM_CHECKSUM_EN
        if (xfer && last) state_nx = CHK;
`else
        if (xfer && last) state_nx = RUN;
`endif
      end
`ifdef BOOTMEM_CHECKSUM_EN
      CHK: begin
        if (xfer) state_nx = (sum_nx == '0) ? RUN : ERR;
      end
      ERR: begin
        if (reload) state_nx = LEN;
      end
`endif
      RUN: begin
        if (reload) state_nx = LEN;
      end
      default: state_nx = LEN;
    endcase
  end

  // Loader pointer, remaining count and running sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      rem <= '0;
`ifdef BOOTMEM_CHECKSUM_EN
      sum <= '0;
`endif
    end else if (xfer) begin
      case (state)
        LEN: begin
          ptr <= '0;
          rem <= (bus.load_data == '0)
               ? (WIDTH+1)'(DEPTH)
               : {1'b0, bus.load_data};
`ifdef BOOTMEM_CHECKSUM_EN
          sum <= '0;
`endif
        end
        DATA: begin
          ptr <= ptr + 1'b1;
          rem <= rem - 1'b1;
`ifdef BOOTMEM_CHECKSUM_EN
          sum <= sum_nx;
`endif
        end
        default: begin
          ptr <= ptr;
          rem <= rem;
        end
      endcase
    end
  end

  // Memory array: loader writes while loading, core writes in RUN
  always_ff @(posedge clk) begin
    if (xfer && state == DATA)
      mem[ptr] <= bus.load_data;
    else if (run && bus.memwrite)
      mem[bus.adr] <= bus.writedata;
  end

endmodule
